// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// Holds the FSM encoding, the AES block width and the default timeout.
package aes_sched_pkg;

  localparam int         BLK_W       = 128;
  localparam logic [7:0] TIMEOUT_DEF = 8'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Round-robin requester selection: the first valid index at or above rr_ptr, wrapping.
// Purely combinational; the caller decides when a grant is actually taken.
module aes_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index,
  output logic            any
);

  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IW'((int'(rr_ptr) + i) % NREQ);
      if (!any && req_valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = j;
      end
    end
  end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one AES core among NREQ requesters, one job at a time, with a RUN timeout.
//
// state   | meaning
// IDLE    | no job held; grant round-robin and latch text/key/index
// RUN     | core_start high, waiting for core_done or timeout
// RESP    | response presented until the consumer accepts it
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter  int         NREQ    = 4,
  parameter  logic [7:0] TIMEOUT = TIMEOUT_DEF,
  localparam int         IW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [BLK_W*NREQ-1:0] req_text,
  input  logic [BLK_W*NREQ-1:0] req_key,
  output logic                  core_start,
  output logic [BLK_W-1:0]      core_text,
  output logic [BLK_W-1:0]      core_key,
  input  logic                  core_done,
  input  logic [BLK_W-1:0]      core_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLK_W-1:0]      resp_data,
  output logic [IW-1:0]         resp_id,
  output logic                  resp_err
);

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      cnt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;

  aes_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .index     (pick_idx),
    .any       (pick_any)
  );

  assign accept     = (state == ST_IDLE) && pick_any;
  // gated by rstn so the accept pulse vanishes the instant reset asserts
  assign req_ready  = (accept && rstn) ? pick_grant : '0;
  assign core_start = (state == ST_RUN);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_any) state_nx = ST_RUN;
      ST_RUN:  if (core_done || cnt == TIMEOUT) state_nx = ST_RESP;
      ST_RESP: if (resp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      core_text <= '0;
      core_key  <= '0;
      resp_data <= '0;
      resp_id   <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        core_text <= req_text[pick_idx*BLK_W +: BLK_W];
        core_key  <= req_key[pick_idx*BLK_W +: BLK_W];
        resp_id   <= pick_idx;
        resp_data <= '0;
        resp_err  <= 1'b0;
        cnt       <= '0;
      end
      if (state == ST_RUN) begin
        if (cnt != TIMEOUT) cnt <= cnt + 8'd1;
        // a done arriving on the timeout cycle still counts as success
        if (core_done) begin
          resp_data <= core_result;
          resp_err  <= 1'b0;
        end else if (cnt == TIMEOUT) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
      if (state == ST_RESP && resp_ready)
        rr_ptr <= (resp_id == IW'(NREQ-1)) ? '0 : resp_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_job_sched.sv
// Bench for aes_job_sched: behavioural core, job-level reference model, per-cycle compare.
// Directed scenarios add literal expectations for grant order, latency and timeout behaviour.
module tb_aes_job_sched;
  localparam int         NREQ = 4;
  localparam logic [7:0] TO   = 8'd63;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [128*NREQ-1:0] req_text, req_key;
  logic                core_start;
  logic [127:0]        core_text, core_key;
  logic                core_done;
  logic [127:0]        result_val = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [127:0]        resp_data;
  logic [1:0]          resp_id;
  logic                resp_err;

  int checks = 0;
  int errors = 0;

  aes_job_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_text(req_text), .req_key(req_key), .core_start(core_start),
    .core_text(core_text), .core_key(core_key), .core_done(core_done),
    .core_result(result_val), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] text_of(int i);
    return {4{32'h7E57_0000 + 32'(i)}};
  endfunction
  function automatic logic [127:0] key_of(int i);
    return {4{32'hC0DE_0100 + 32'(i)}};
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_text[i*128 +: 128] = text_of(i);
      req_key[i*128 +: 128]  = key_of(i);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // behavioural core: done after done_at+1 cycles of core_start; glitch drives done anytime
  int   core_cnt = 0;
  int   done_at = 1000;
  logic done_glitch = 1'b0;
  always @(posedge clk) core_cnt <= core_start ? core_cnt + 1 : 0;
  assign core_done = (core_start && core_cnt == done_at) || done_glitch;

  // job-level reference model
  logic         m_busy, m_hold, m_err;
  int           m_own, m_runs, m_rr;
  logic [127:0] m_text, m_key, m_data;
  int           m_grants[$];
  int           dut_grants[$];

  function automatic int pick(logic [NREQ-1:0] v, int rr);
    for (int j = 0; j < NREQ; j++)
      if (v[(rr + j) % NREQ]) return (rr + j) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0;
      m_own <= 0; m_runs <= 0; m_rr <= 0;
      m_text <= '0; m_key <= '0; m_data <= '0;
    end else if (m_busy) begin
      if (core_done) begin
        m_busy <= 1'b0; m_hold <= 1'b1; m_data <= result_val; m_err <= 1'b0;
      end else if (m_runs == int'(TO)) begin
        m_busy <= 1'b0; m_hold <= 1'b1; m_data <= '0; m_err <= 1'b1;
      end else begin
        m_runs <= m_runs + 1;
      end
    end else if (m_hold) begin
      if (resp_ready) begin
        m_hold <= 1'b0;
        m_rr   <= (m_own + 1) % NREQ;
      end
    end else if (pick(req_valid, m_rr) >= 0) begin
      m_busy <= 1'b1;
      m_own  <= pick(req_valid, m_rr);
      m_runs <= 0;
      m_text <= text_of(pick(req_valid, m_rr));
      m_key  <= key_of(pick(req_valid, m_rr));
      m_grants.push_back(pick(req_valid, m_rr));
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_core_start", 128'(core_start), 128'd0);
      chk("rst_req_ready", 128'(req_ready), 128'd0);
      chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    end else begin
      int g;
      g = (m_busy || m_hold) ? -1 : pick(req_valid, m_rr);
      chk("req_ready", 128'(req_ready), (g < 0) ? 128'd0 : (128'd1 << g));
      chk("core_start", 128'(core_start), 128'(m_busy));
      chk("resp_valid", 128'(resp_valid), 128'(m_hold));
      if (m_busy) begin
        chk("core_text", core_text, m_text);
        chk("core_key", core_key, m_key);
      end
      if (m_hold) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_id", 128'(resp_id), 128'(m_own));
        chk("resp_err", 128'(resp_err), 128'(m_err));
      end
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k]) dut_grants.push_back(k);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_resp(input string name, output int runs);
    int n;
    n = 0;
    runs = 0;
    while (!resp_valid && n < 300) begin
      if (core_start) runs++;
      tick(1);
      n++;
    end
    chk(name, 128'(resp_valid), 128'd1);
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    chk(name, 128'(resp_valid), 128'd0);
  endtask

  // start a single job from the given valid mask; returns positioned in the first RUN cycle
  task automatic launch(input logic [NREQ-1:0] v);
    req_valid = v;
    tick(1);
    req_valid = '0;
  endtask

  initial begin
    int runs, n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    #2;
    chk("init_core_text", core_text, 128'd0);
    chk("init_resp_id", 128'(resp_id), 128'd0);
    chk("init_resp_err", 128'(resp_err), 128'd0);
    tick(2);
    rstn = 1'b1;

    // single job, done at RUN cycle 44
    done_at = 44;
    result_val = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    req_valid = 4'b0001;
    #3;
    chk("t1_req_ready", 128'(req_ready), 128'h1);
    @(posedge clk); #1;
    req_valid = '0;
    chk("t1_core_start", 128'(core_start), 128'd1);
    chk("t1_core_key", core_key, {4{32'hC0DE_0100}});
    wait_resp("t1_resp", runs);
    chk("t1_runs", 128'(runs), 128'd45);
    chk("t1_data", resp_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t1_id", 128'(resp_id), 128'd0);
    chk("t1_err", 128'(resp_err), 128'd0);
    handshake("t1_hs");

    // all requesters pending: round-robin order from a fresh pointer
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    dut_grants.delete();
    m_grants.delete();
    done_at = 3;
    result_val = 128'hAAAA;
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    n = 0;
    while (dut_grants.size() < 5 && n < 200) begin tick(1); n++; end
    req_valid = '0;
    n = 0;
    while ((core_start || resp_valid) && n < 50) begin tick(1); n++; end
    resp_ready = 1'b0;
    chk("t2_grant_count", 128'(dut_grants.size()), 128'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < dut_grants.size()) chk("t2_dut_order", 128'(dut_grants[i]), 128'(exp_order[i]));
      if (i < m_grants.size())   chk("t2_model_order", 128'(m_grants[i]), 128'(exp_order[i]));
    end

    // timeout on requester 1, then a normal job on requester 2
    done_at = 1000;
    launch(4'b0010);
    wait_resp("t3_resp", runs);
    chk("t3_runs", 128'(runs), 128'd64);
    chk("t3_err", 128'(resp_err), 128'd1);
    chk("t3_data", resp_data, 128'd0);
    chk("t3_id", 128'(resp_id), 128'd1);
    handshake("t3_hs");
    done_at = 5;
    result_val = 128'hBEEF_0000_1111_2222;
    launch(4'b0100);
    wait_resp("t3b_resp", runs);
    chk("t3b_runs", 128'(runs), 128'd6);
    chk("t3b_err", 128'(resp_err), 128'd0);
    chk("t3b_data", resp_data, 128'hBEEF_0000_1111_2222);
    chk("t3b_id", 128'(resp_id), 128'd2);
    handshake("t3b_hs");

    // response back-pressure with stray done and pending requests
    done_at = 2;
    result_val = 128'hCAFE;
    launch(4'b1000);
    wait_resp("t4_resp", runs);
    req_valid = 4'b1111;
    done_glitch = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t4_hold_valid", 128'(resp_valid), 128'd1);
      chk("t4_hold_data", resp_data, 128'hCAFE);
      chk("t4_hold_id", 128'(resp_id), 128'd3);
      chk("t4_hold_ready", 128'(req_ready), 128'd0);
      chk("t4_hold_start", 128'(core_start), 128'd0);
    end
    req_valid = '0;
    handshake("t4_hs");
    tick(1);
    chk("t4_idle_start", 128'(core_start), 128'd0);
    chk("t4_idle_valid", 128'(resp_valid), 128'd0);
    done_glitch = 1'b0;

    // reset in the middle of RUN
    done_at = 30;
    result_val = 128'h5555;
    req_valid = 4'b0100;
    tick(11);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_core_start", 128'(core_start), 128'd0);
    chk("t5_req_ready", 128'(req_ready), 128'd0);
    chk("t5_resp_valid", 128'(resp_valid), 128'd0);
    chk("t5_resp_err", 128'(resp_err), 128'd0);
    chk("t5_resp_data", resp_data, 128'd0);
    chk("t5_resp_id", 128'(resp_id), 128'd0);
    chk("t5_core_text", core_text, 128'd0);
    chk("t5_core_key", core_key, 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #3;
    chk("t5_regrant", 128'(req_ready), 128'h4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp("t5_resp", runs);
    chk("t5_runs", 128'(runs), 128'd31);
    chk("t5_id", 128'(resp_id), 128'd2);
    handshake("t5_hs");

    // done on the very cycle the counter reaches TIMEOUT; pointer wraps 3 -> 0
    done_at = 63;
    result_val = 128'hD0D0_0063;
    launch(4'b0001);
    wait_resp("t6_resp", runs);
    chk("t6_runs", 128'(runs), 128'd64);
    chk("t6_err", 128'(resp_err), 128'd0);
    chk("t6_data", resp_data, 128'hD0D0_0063);
    chk("t6_id", 128'(resp_id), 128'd0);
    handshake("t6_hs");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_job_sched.md
AES_JOB_SCHED -- requirements
Module: aes_job_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one AES core (2..8).
REQ-002 Parameter TIMEOUT, default 8'd63, maximum RUN cycles to wait for core_done.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester job pending.
REQ-006 req_ready  output  NREQ  one-hot, one-cycle job-accept pulse.
REQ-007 req_text  input  128*NREQ  plaintext; slice i belongs to requester i.
REQ-008 req_key  input  128*NREQ  cipher key; slice i belongs to requester i.
REQ-009 core_start  output  1  held high for the whole job; low returns the core to round 0.
REQ-010 core_text  output  128  latched plaintext to the core.
REQ-011 core_key  output  128  latched key to the core.
REQ-012 core_done  input  1  core final-round indicator.
REQ-013 core_result  input  128  ciphertext from the core.
REQ-014 resp_valid  output  1  response available.
REQ-015 resp_ready  input  1  consumer accepts the response.
REQ-016 resp_data  output  128  ciphertext, or zero on error.
REQ-017 resp_id  output  clog2(NREQ)  index of the requester that owns the response.
REQ-018 resp_err  output  1  job timed out.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and RESP, and SHALL hold only one job at a time.
REQ-020 IDLE, any req_valid: the block SHALL grant the first set index at or above rr_ptr, wrapping modulo NREQ.
  - It SHALL pulse req_ready for that index in the same cycle.
  - It SHALL latch the text, key and index.
  - It SHALL enter RUN on the next edge.
REQ-021 IDLE with no req_valid: the block SHALL stay in IDLE with all req_ready low.
REQ-022 req_ready SHALL be all-zero in RUN and RESP, and no new job SHALL be accepted while busy.
REQ-023 core_start SHALL be 1 exactly in RUN, with core_text and core_key stable from the latches.
REQ-024 RUN cycle counter:
  - It SHALL clear on entry to RUN.
  - It SHALL increment each RUN cycle.
  - It SHALL saturate at TIMEOUT and never wrap.
REQ-025 RUN with core_done=1: the block SHALL latch core_result into resp_data, clear resp_err and go to RESP, so core_start falls on the next cycle.
REQ-026 RUN with core_done=0 and counter==TIMEOUT: the block SHALL go to RESP with resp_data=0 and resp_err=1.
REQ-027 If core_done=1 in the same cycle the counter equals TIMEOUT, done SHALL win and resp_err SHALL be 0.
REQ-028 core_done SHALL be ignored in IDLE and RESP.
REQ-029 RESP: resp_valid SHALL be 1, and resp_data, resp_id and resp_err SHALL be stable until resp_ready=1.
REQ-030 RESP with resp_ready=1: the block SHALL return to IDLE, set rr_ptr=(granted index+1) mod NREQ, and drop resp_valid on the next cycle.
REQ-031 resp_ready=1 in the first RESP cycle SHALL complete the handshake in that cycle.
REQ-032 Minimum back-to-back spacing SHALL be one IDLE cycle between jobs.
REQ-033 A req_valid that deasserts before grant SHALL simply not be considered.

Reset
REQ-034 rstn low at any time SHALL immediately force the following:
  - state=IDLE, rr_ptr=0, counter=0.
  - core_start=0, req_ready=0, resp_valid=0, resp_err=0.
  - resp_data=0, resp_id=0, core_text=0, core_key=0.
REQ-035 Reset mid-RUN SHALL abandon the job with no response, and core_start low SHALL return the core to round 0.

Structure
REQ-036 Package aes_sched_pkg SHALL hold the FSM state encoding, the 128-bit block width constant and the default TIMEOUT.
REQ-037 The round-robin selection SHALL be a combinational sub-module aes_rr_pick.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant, index, any.

Verification
REQ-038 After reset, req_valid=4'b0001: req_ready=0001 for one cycle, core_start high; behavioural core asserts done at RUN cycle 44 with result X -> resp_valid=1, resp_data=X, resp_id=0, resp_err=0.
REQ-039 req_valid=4'b1111 held, resp_ready=1: grants SHALL occur in order 0,1,2,3,0, with one job in flight at a time.
REQ-040 Core never asserts done -> resp_err=1, resp_data=0 after TIMEOUT+1 RUN cycles; next job proceeds normally.
REQ-041 resp_ready held low 20 cycles in RESP -> outputs stable, req_ready=0 throughout, core_start=0; then resp_ready=1 -> IDLE next cycle.
REQ-042 rstn pulsed low mid-RUN with req_valid=4'b0100 -> all outputs 0 asynchronously; after release, requester 2 is re-granted with rr_ptr=0.
REQ-043 core_done asserted exactly at counter==TIMEOUT -> resp_err=0, resp_data=core_result.
